// File: rtl/avr_addr_sequencer_if.sv
// AVR command-muxer levels in, cartridge ROM/SRAM bus control out.
// master = command side, slave = sequencer.
interface avr_addr_sequencer_if #(
  parameter int ADDR_W = 24
);
  logic              avr_snes_mode;
  logic              avr_si;
  logic              avr_sreg_en_n;
  logic              avr_counter_n;
  logic              avr_we_n;
  logic              avr_oe_n;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_oe_n;
  logic              rom_we_n;
  logic              addr_valid;
  logic              addr_wrap;
  logic              busy;

  modport master (
    output avr_snes_mode, avr_si, avr_sreg_en_n,
    output avr_counter_n, avr_we_n, avr_oe_n,
    input  rom_addr, rom_oe_n, rom_we_n,
    input  addr_valid, addr_wrap, busy
  );

  modport slave (
    input  avr_snes_mode, avr_si, avr_sreg_en_n,
    input  avr_counter_n, avr_we_n, avr_oe_n,
    output rom_addr, rom_oe_n, rom_we_n,
    output addr_valid, addr_wrap, busy
  );
endinterface

// File: rtl/avr_addr_sequencer.sv
// Serial address load, auto-increment, OE gating and timed WE pulses
// for the cartridge ROM/SRAM bus.
module avr_addr_sequencer #(
  parameter int ADDR_W   = 24,
  parameter int WE_PULSE = 4
) (
  input logic                 avr_clk,
  input logic                 avr_reset,
  avr_addr_sequencer_if.slave bus
);
  localparam int BW  = $clog2(ADDR_W + 1);
  localparam int WCW = (WE_PULSE > 1) ? $clog2(WE_PULSE) : 1;
  localparam logic [BW-1:0]     LAST  = BW'(ADDR_W - 1);
  localparam logic [WCW-1:0]    WLEN  = WCW'(WE_PULSE - 1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFTING,
    LOADED
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] shreg, shreg_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [BW-1:0]     bitcnt, bitcnt_nxt;
  logic [WCW-1:0]    wcnt, wcnt_nxt;
  logic              valid, valid_nxt;
  logic              wrap, wrap_nxt;
  logic              busy, busy_nxt;
  logic              we_n, we_nxt;
  logic              oe_n, oe_nxt;
  logic              pinc, pinc_nxt;
  logic              pld, pld_nxt;
  logic              inc_go;

  logic s_si, s_sreg, s_cnt, s_we, s_oe;
  logic p_sreg, p_cnt, p_we;
  logic sreg_fall, cnt_fall, we_fall;
  logic snes;

  assign snes      = bus.avr_snes_mode;
  assign sreg_fall = p_sreg & ~s_sreg;
  assign cnt_fall  = p_cnt & ~s_cnt;
  assign we_fall   = p_we & ~s_we;

  // Strobe samples reset high so leaving reset never looks like a fall
  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      s_si   <= 1'b0;
      s_sreg <= 1'b1;
      s_cnt  <= 1'b1;
      s_we   <= 1'b1;
      s_oe   <= 1'b1;
      p_sreg <= 1'b1;
      p_cnt  <= 1'b1;
      p_we   <= 1'b1;
    end else begin
      s_si   <= bus.avr_si;
      s_sreg <= bus.avr_sreg_en_n;
      s_cnt  <= bus.avr_counter_n;
      s_we   <= bus.avr_we_n;
      s_oe   <= bus.avr_oe_n;
      p_sreg <= s_sreg;
      p_cnt  <= s_cnt;
      p_we   <= s_we;
    end
  end

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      state  <= IDLE;
      shreg  <= '0;
      addr   <= '0;
      bitcnt <= '0;
      wcnt   <= '0;
      valid  <= 1'b0;
      wrap   <= 1'b0;
      busy   <= 1'b0;
      we_n   <= 1'b1;
      oe_n   <= 1'b1;
      pinc   <= 1'b0;
      pld    <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      addr   <= addr_nxt;
      bitcnt <= bitcnt_nxt;
      wcnt   <= wcnt_nxt;
      valid  <= valid_nxt;
      wrap   <= wrap_nxt;
      busy   <= busy_nxt;
      we_n   <= we_nxt;
      oe_n   <= oe_nxt;
      pinc   <= pinc_nxt;
      pld    <= pld_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    addr_nxt   = addr;
    bitcnt_nxt = bitcnt;
    wcnt_nxt   = wcnt;
    valid_nxt  = valid;
    wrap_nxt   = wrap;
    busy_nxt   = busy;
    we_nxt     = we_n;
    pinc_nxt   = pinc;
    pld_nxt    = pld;
    inc_go     = 1'b0;

    if (sreg_fall) begin
      shreg_nxt = {shreg[ADDR_W-2:0], s_si};
      if (state != SHIFTING) begin
        state_nxt  = SHIFTING;
        bitcnt_nxt = BW'(1);
        valid_nxt  = 1'b0;
        wrap_nxt   = 1'b0;
        pinc_nxt   = 1'b0;
        pld_nxt    = 1'b0;
      end else if (bitcnt == LAST) begin
        state_nxt  = LOADED;
        bitcnt_nxt = '0;
        valid_nxt  = 1'b1;
        if (busy) pld_nxt = 1'b1;
        else addr_nxt = shreg_nxt;
      end else begin
        bitcnt_nxt = bitcnt + BW'(1);
      end
    end else if (cnt_fall && state == LOADED) begin
      if (!busy) inc_go = 1'b1;
      else if (!snes) pinc_nxt = 1'b1;
    end

    if (busy) begin
      if (snes) begin
        busy_nxt = 1'b0;
        we_nxt   = 1'b1;
        wcnt_nxt = '0;
        pinc_nxt = 1'b0;
      end else if (wcnt == '0) begin
        busy_nxt = 1'b0;
        we_nxt   = 1'b1;
        inc_go   = pinc_nxt;
        pinc_nxt = 1'b0;
      end else begin
        wcnt_nxt = wcnt - WCW'(1);
      end
      // Deferred final-bit transfer lands once the bus is free
      if (!busy_nxt && pld_nxt) begin
        addr_nxt = shreg_nxt;
        pld_nxt  = 1'b0;
      end
    end else if (we_fall && state == LOADED && !snes) begin
      busy_nxt = 1'b1;
      we_nxt   = 1'b0;
      wcnt_nxt = WLEN;
    end

    if (inc_go) begin
      if (&addr_nxt) wrap_nxt = 1'b1;
      addr_nxt = addr_nxt + A_ONE;
    end

    oe_nxt = s_oe | snes | ~valid_nxt | busy_nxt;
  end

  assign bus.rom_addr   = addr;
  assign bus.rom_oe_n   = oe_n;
  assign bus.rom_we_n   = we_n;
  assign bus.addr_valid = valid;
  assign bus.addr_wrap  = wrap;
  assign bus.busy       = busy;
endmodule
